sdram_arbiter: RTL and testbench

// - Shares one SDRAM controller port between NUM_PORTS requesters (e.g. PRG read, CHR read, loader write).
// - Latches single-cycle request pulses, grants one at a time, issues one SDRAM access, routes read data/ack back.
// - Sits between the per-bus cache front-ends (PRG/CHR) and the SDRAM controller; the only master of that controller.

---
 rtl/sdram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between NUM_PORTS requesters.
// Each port's request pulse is latched into a single pending entry.
// Pending entries are granted one at a time, and each grant becomes exactly
// one SDRAM access. Only one access is outstanding at any time.
// Optional macro SDRAM_ARB_RR_EN selects round-robin arbitration.
// Without it, arbitration is fixed priority and port 0 wins.
//
// state  | meaning
// S_IDLE | no access outstanding; grant a pending port if any
// S_WAIT | access issued; wait for mem_ack, then acknowledge the port
module sdram_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_BITS = 22,
  parameter int DATA_BITS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           port_req,
  input  logic [NUM_PORTS-1:0]           port_we,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_BITS-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]           port_ack,
  output logic [DATA_BITS-1:0]           port_rdata,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_BITS-1:0]           mem_addr,
  output logic [DATA_BITS-1:0]           mem_wdata,
  input  logic [DATA_BITS-1:0]           mem_rdata,
  input  logic                           mem_ack
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state, state_nxt;
  logic [NUM_PORTS-1:0]   pending;
  logic [NUM_PORTS-1:0]   lat_we;
  logic [ADDR_BITS-1:0]   lat_addr  [NUM_PORTS];
  logic [DATA_BITS-1:0]   lat_wdata [NUM_PORTS];
  logic [PW-1:0]          gnt_sel;
  logic [PW-1:0]          gnt;
  logic                   issue;
  logic                   done;

`ifdef SDRAM_ARB_RR_EN
  logic [PW-1:0]          rr_ptr;

  // Round-robin pick: search pending entries starting at rr_ptr, wrapping around
  always_comb begin
    int  idx;
    logic found;
    gnt_sel = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && pending[idx]) begin
        gnt_sel = PW'(idx);
        found   = 1'b1;
      end
    end
  end

  // Advance the round-robin pointer past the port that was just granted
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (issue) rr_ptr <= (gnt_sel == PW'(NUM_PORTS - 1)) ? '0 : gnt_sel + 1'b1;
  end
`else
  // Fixed-priority pick: the lowest pending index wins
  always_comb begin
    gnt_sel = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (pending[k]) gnt_sel = PW'(k);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|pending) state_nxt = S_WAIT;
      S_WAIT:  if (mem_ack)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: issue starts an access, done completes it
  always_comb begin
    issue = (state == S_IDLE) && (|pending);
    done  = (state == S_WAIT) && mem_ack;
  end

  // Request capture. A new pulse overrides a same-edge grant clear, so a
  // re-request is never lost. The latest request overwrites the latched fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      lat_we  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        lat_addr[i]  <= '0;
        lat_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (issue && (gnt_sel == PW'(i))) pending[i] <= 1'b0;
        if (port_req[i]) begin
          pending[i]   <= 1'b1;
          lat_we[i]    <= port_we[i];
          lat_addr[i]  <= port_addr[i*ADDR_BITS +: ADDR_BITS];
          lat_wdata[i] <= port_wdata[i*DATA_BITS +: DATA_BITS];
        end
      end
    end
  end

  // Drive the controller: one-cycle strobe, fields held until the next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt       <= '0;
    end else begin
      mem_req <= issue;
      if (issue) begin
        mem_we    <= lat_we[gnt_sel];
        mem_addr  <= lat_addr[gnt_sel];
        mem_wdata <= lat_wdata[gnt_sel];
        gnt       <= gnt_sel;
      end
    end
  end

  // Return the completion to the granted port; only reads update port_rdata
  always_ff @(posedge clk) begin
    if (rst) begin
      port_ack   <= '0;
      port_rdata <= '0;
    end else begin
      port_ack <= '0;
      if (done) begin
        port_ack <= NUM_PORTS'(1) << gnt;
        if (!mem_we) port_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter.
// The bench runs these scenarios in order: latency, write path, arbitration
// order, request overwrite, reset mid-access, and starvation versus round-robin.
module tb_sdram_arbiter;
  localparam int NP = 3;
  localparam int AB = 22;
  localparam int DB = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     port_req = '0;
  logic [NP-1:0]     port_we = '0;
  logic [NP*AB-1:0]  port_addr = '0;
  logic [NP*DB-1:0]  port_wdata = '0;
  logic [NP-1:0]     port_ack;
  logic [DB-1:0]     port_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [AB-1:0]     mem_addr;
  logic [DB-1:0]     mem_wdata;
  logic [DB-1:0]     mem_rdata = '0;
  logic              mem_ack = 1'b0;

  int total = 0;
  int bad = 0;
  logic [DB-1:0] exp_rd = '0;

  sdram_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_ack(port_ack), .port_rdata(port_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; single-cycle pulses are withdrawn and outputs are settled afterwards
  task automatic step();
    @(posedge clk);
    #1;
    port_req = '0;
    mem_ack  = 1'b0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [AB-1:0] addr, input logic [DB-1:0] wd);
    port_req[p]            = 1'b1;
    port_we[p]             = we;
    port_addr[p*AB +: AB]  = addr;
    port_wdata[p*DB +: DB] = wd;
  endtask

  // Serve one access: check the strobe and its fields, inject re-requests while
  // waiting, ack three cycles after mem_req, then check the port completion.
  task automatic access(input string tag, input int p, input logic we, input logic [AB-1:0] addr,
                        input logic [DB-1:0] wd, input logic [DB-1:0] rd,
                        input logic [NP-1:0] inj, input logic [AB-1:0] inj_base);
    int n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    check({tag, " mem_req"}, 32'(mem_req), 32'd1);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(addr));
    check({tag, " mem_we"}, 32'(mem_we), 32'(we));
    if (we) check({tag, " mem_wdata"}, 32'(mem_wdata), 32'(wd));
    for (int i = 0; i < NP; i++) begin
      if (inj[i]) set_req(i, 1'b0, inj_base + AB'(i), '0);
    end
    step();
    check({tag, " req_pulse"}, 32'(mem_req), 32'd0);
    step();
    step();
    mem_ack   = 1'b1;
    mem_rdata = rd;
    check({tag, " ack_early"}, 32'(port_ack), 32'd0);
    step();
    if (!we) exp_rd = rd;
    check({tag, " port_ack"}, 32'(port_ack), 32'(1 << p));
    check({tag, " port_rdata"}, 32'(port_rdata), 32'(exp_rd));
    check({tag, " gap"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    int cnt_req;
    int cnt_ack;
    #1;
    step();
    step();
    rst = 1'b0;
    check("rst port_ack", 32'(port_ack), 32'd0);
    check("rst port_rdata", 32'(port_rdata), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);

    // t1: port0 read, latency from request to strobe
    set_req(0, 1'b0, 22'h000123, 16'h0);
    step();
    check("t1 mem_req t+1", 32'(mem_req), 32'd0);
    step();
    check("t1 mem_req t+2", 32'(mem_req), 32'd1);
    access("t1", 0, 1'b0, 22'h000123, 16'h0, 16'hBEEF, '0, '0);

    // t2: port2 write to top address, port_rdata untouched
    set_req(2, 1'b1, 22'h3FFFFF, 16'h55AA);
    step();
    access("t2", 2, 1'b1, 22'h3FFFFF, 16'h55AA, 16'h1234, '0, '0);

    // t3: all ports at once, then re-requests on 0 and 2 during port1's access
    set_req(0, 1'b0, 22'h0000A0, 16'h0);
    set_req(1, 1'b0, 22'h0000A1, 16'h0);
    set_req(2, 1'b0, 22'h0000A2, 16'h0);
    step();
    access("t3a", 0, 1'b0, 22'h0000A0, 16'h0, 16'h1111, '0, '0);
    access("t3b", 1, 1'b0, 22'h0000A1, 16'h0, 16'h2222, 3'b101, 22'h000100);
`ifdef SDRAM_ARB_RR_EN
    access("t3c", 2, 1'b0, 22'h000102, 16'h0, 16'h3333, '0, '0);
    access("t3d", 0, 1'b0, 22'h000100, 16'h0, 16'h4444, '0, '0);
`else
    access("t3c", 0, 1'b0, 22'h000100, 16'h0, 16'h3333, '0, '0);
    access("t3d", 2, 1'b0, 22'h000102, 16'h0, 16'h4444, '0, '0);
`endif

    // t4: port1 overwritten before grant yields one access to the later address
    set_req(0, 1'b0, 22'h000040, 16'h0);
    step();
    set_req(1, 1'b0, 22'h000010, 16'h0);
    step();
    access("t4a", 0, 1'b0, 22'h000040, 16'h0, 16'h5555, 3'b010, 22'h00001F);
    access("t4b", 1, 1'b0, 22'h000020, 16'h0, 16'h6666, '0, '0);
    cnt_req = 0;
    cnt_ack = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req) cnt_req++;
      if (|port_ack) cnt_ack++;
    end
    check("t4 extra mem_req", 32'(cnt_req), 32'd0);
    check("t4 extra ack", 32'(cnt_ack), 32'd0);

    // t5: reset while waiting, then a late mem_ack
    set_req(1, 1'b0, 22'h000300, 16'h0);
    step();
    step();
    check("t5 mem_req", 32'(mem_req), 32'd1);
    step();
    set_req(2, 1'b0, 22'h000301, 16'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rd = '0;
    check("t5 rst mem_addr", 32'(mem_addr), 32'd0);
    check("t5 rst port_rdata", 32'(port_rdata), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    check("t5 no ack", 32'(port_ack), 32'd0);
    cnt_req = 0;
    cnt_ack = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req) cnt_req++;
      if (|port_ack) cnt_ack++;
    end
    check("t5 pending cleared", 32'(cnt_req), 32'd0);
    check("t5 ack count", 32'(cnt_ack), 32'd0);
    check("t5 rdata kept", 32'(port_rdata), 32'd0);

    // t6: port0 keeps re-requesting while port1 waits
    set_req(0, 1'b0, 22'h000200, 16'h0);
    set_req(1, 1'b0, 22'h000201, 16'h0);
    step();
`ifdef SDRAM_ARB_RR_EN
    access("t6a", 0, 1'b0, 22'h000200, 16'h0, 16'h7001, 3'b001, 22'h000200);
    access("t6b", 1, 1'b0, 22'h000201, 16'h0, 16'h7002, '0, '0);
    access("t6c", 0, 1'b0, 22'h000200, 16'h0, 16'h7003, '0, '0);
`else
    access("t6a", 0, 1'b0, 22'h000200, 16'h0, 16'h7001, 3'b001, 22'h000200);
    access("t6b", 0, 1'b0, 22'h000200, 16'h0, 16'h7002, 3'b001, 22'h000200);
    access("t6c", 0, 1'b0, 22'h000200, 16'h0, 16'h7003, '0, '0);
    access("t6d", 1, 1'b0, 22'h000201, 16'h0, 16'h7004, '0, '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
